tb_dut_access_arbiter: RTL

- Round-robin arbiter that shares the single DUT-side interface between several test-bench stimulus agents.
- Sits inside the test-bench hook-up, between the stimulus agents and the DUT interface, and runs on the test-bench clock.
- Each agent requests ownership, holds it for a multi-cycle transaction and releases it.
- An optional watchdog revokes ownership from an agent that hangs.

---
 rtl/tb_dut_access_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/tb_dut_access_arbiter.sv
// tb_dut_access_arbiter
// Round-robin arbiter that hands the single DUT-side interface to one of
// NUM_REQ stimulus agents at a time. An owner keeps the grant until it
// pulses done, drops its request, or (optional) the watchdog revokes it.
// After every release the grant stays low for one turnaround cycle.
//
// Optional feature macro: TB_ARB_WATCHDOG_EN
//   defined   -> hold counter, watchdog revocation, timeout_err/timeout_sticky
//   undefined -> no counter; ownership may last indefinitely; timeout
//                outputs tied low (ports still present)

module tb_dut_access_arbiter #(
  parameter  int NUM_REQ        = 4,
  parameter  int TIMEOUT_CYCLES = 256,
  localparam int IDX_W          = $clog2(NUM_REQ)
) (
  input  logic               tb_clk,
  input  logic               tb_rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   owner,
  output logic               busy,
  output logic               timeout_err,
  output logic               timeout_sticky
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  // Out-of-range configurations elaborate an empty, visibly named scope so
  // they are easy to spot in a hierarchy dump.
  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 2) begin : g_param_range_violation
  end

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               busy_q, busy_d;
  logic [IDX_W-1:0]   last_q, last_d;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic               rel_normal;
  logic               wd_expire;

  // Circular search starting just after the last owner. Offsets are scanned
  // from farthest to nearest so the nearest requesting agent overwrites the
  // rest; offset NUM_REQ is the last owner itself, i.e. lowest priority.
  always_comb begin
    int idx;
    pick_valid = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(last_q) + i) % NUM_REQ;
      if (req[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(idx);
      end
    end
  end

  // Owner-driven release: transaction complete or the agent walked away.
  // done bits of non-owners never reach this term.
  always_comb begin
    rel_normal = done[owner_q] | ~req[owner_q];
  end

  // Next-state and registered-output computation for the ownership FSM.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    busy_d  = busy_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_OWN;
          gnt_d   = NUM_REQ'(1) << pick_idx;
          owner_d = pick_idx;
          busy_d  = 1'b1;
        end
      end
      ST_OWN: begin
        // Release always passes through IDLE, which yields the one-cycle
        // bus turnaround even when other agents are waiting. owner keeps
        // its value so it still names the agent that just finished.
        if (rel_normal || wd_expire) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          last_d  = owner_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Ownership FSM state and registered outputs.
  always_ff @(posedge tb_clk) begin
    if (tb_rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      last_q  <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
    end
  end

`ifdef TB_ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic             timeout_sticky_q, timeout_sticky_d;

  // Counter sits at 0 on the first owned cycle, so expiry at CNT_MAX gives
  // exactly TIMEOUT_CYCLES cycles of grant.
  always_comb begin
    wd_expire = (state_q == ST_OWN) && (cnt_q == CNT_MAX);
  end

  // Hold counter and timeout flags; an owner release in the same cycle as
  // expiry wins, so it is never reported as a timeout.
  always_comb begin
    cnt_d            = cnt_q;
    timeout_err_d    = 1'b0;
    timeout_sticky_d = timeout_sticky_q;
    if (state_q == ST_OWN) begin
      if (rel_normal || wd_expire) begin
        cnt_d            = '0;
        timeout_err_d    = wd_expire & ~rel_normal;
        timeout_sticky_d = timeout_sticky_q | (wd_expire & ~rel_normal);
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Watchdog registers.
  always_ff @(posedge tb_clk) begin
    if (tb_rst) begin
      cnt_q            <= '0;
      timeout_err_q    <= 1'b0;
      timeout_sticky_q <= 1'b0;
    end else begin
      cnt_q            <= cnt_d;
      timeout_err_q    <= timeout_err_d;
      timeout_sticky_q <= timeout_sticky_d;
    end
  end

  assign timeout_err    = timeout_err_q;
  assign timeout_sticky = timeout_sticky_q;
`else
  // Without the watchdog nothing ever revokes a grant.
  assign wd_expire      = 1'b0;
  assign timeout_err    = 1'b0;
  assign timeout_sticky = 1'b0;
`endif

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign busy  = busy_q;

endmodule
